// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage data-memory access unit.
// Issues one req/ready bus transfer per load/store held in EX/MEM. It formats
// byte/half/word lanes, sign- or zero-extends load results, and stalls the
// pipeline until the bus answers or the wait budget runs out.
// Optional feature macro: MISALIGN_TRAP_EN. When defined, misaligned half/word
// accesses are trapped instead of issued.
module mem_access_unit #(
   parameter int WAIT_LIMIT = 16,
   parameter int CNT_W      = 5
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        valid_in,
   input  logic [31:0] ALUResIn,
   input  logic [31:0] RS2In,
   input  logic        dm_writeIn,
   input  logic [2:0]  dm_ctrlIn,
   input  logic [1:0]  ru_data_srcIn,
   input  logic        mem_ready,
   input  logic [31:0] mem_rdata,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_be,
   output logic        stall_out,
   output logic [31:0] load_data,
   output logic        load_valid,
   output logic        bus_err,
   output logic        misalign
);

   typedef enum logic [0:0] {IDLE = 1'b0, BUSY = 1'b1} state_t;

   state_t           state;
   logic [CNT_W-1:0] wait_cnt;
   logic             is_load;      // transfer in flight is a load
   logic [2:0]       ctrl_hold;    // funct3 of the transfer in flight
   logic [1:0]       offset_hold;  // byte offset of the transfer in flight

   logic access;
   logic trap;
   logic issue;
   logic timeout_now;

   // Access size: 0 = byte, 1 = half, 2 = word. Unused funct3 codes act as word.
   function automatic logic [1:0] size_of(input logic [2:0] ctrl);
      logic [1:0] s;
      case (ctrl)
         3'b000, 3'b100: s = 2'd0;
         3'b001, 3'b101: s = 2'd1;
         default:        s = 2'd2;
      endcase
      return s;
   endfunction

   // Byte enables for the addressed lanes.
   function automatic logic [3:0] lane_be(input logic [2:0] ctrl, input logic [1:0] a);
      logic [3:0] be;
      case (size_of(ctrl))
         2'd0:    be = 4'b0001 << a;
         2'd1:    be = a[1] ? 4'b1100 : 4'b0011;
         default: be = 4'b1111;
      endcase
      return be;
   endfunction

   // Store data replicated across all lanes so the byte enables pick the lane.
   function automatic logic [31:0] lane_wdata(input logic [2:0] ctrl, input logic [31:0] d);
      logic [31:0] w;
      case (size_of(ctrl))
         2'd0:    w = {4{d[7:0]}};
         2'd1:    w = {2{d[15:0]}};
         default: w = d;
      endcase
      return w;
   endfunction

   // Extract the addressed byte/half from the bus word and extend it.
   function automatic logic [31:0] format_load(input logic [2:0] ctrl, input logic [1:0] a,
                                               input logic [31:0] rdata);
      logic [31:0] shifted;
      logic [7:0]  byte_v;
      logic [15:0] half_v;
      logic [31:0] r;
      shifted = rdata >> {a, 3'b000};
      byte_v  = shifted[7:0];
      half_v  = a[1] ? rdata[31:16] : rdata[15:0];
      case (ctrl)
         3'b000:  r = {{24{byte_v[7]}}, byte_v};
         3'b100:  r = {24'h000000, byte_v};
         3'b001:  r = {{16{half_v[15]}}, half_v};
         3'b101:  r = {16'h0000, half_v};
         default: r = rdata;
      endcase
      return r;
   endfunction

`ifdef MISALIGN_TRAP_EN
   // Half needs a[0]==0, word needs a==0; bytes are always aligned.
   function automatic logic is_misaligned(input logic [2:0] ctrl, input logic [1:0] a);
      logic m;
      case (size_of(ctrl))
         2'd1:    m = a[0];
         2'd2:    m = (a != 2'b00);
         default: m = 1'b0;
      endcase
      return m;
   endfunction
`endif

   // Decode the EX/MEM request and compute the stall. The timeout cycle also
   // drops the stall so the aborted instruction leaves MEM instead of re-issuing.
   always_comb begin
      access      = valid_in & (dm_writeIn | (ru_data_srcIn == 2'b01));
`ifdef MISALIGN_TRAP_EN
      trap        = (state == IDLE) & access & is_misaligned(dm_ctrlIn, ALUResIn[1:0]);
`else
      trap        = 1'b0;
`endif
      issue       = access & ~trap;
      timeout_now = (state == BUSY) & ~mem_ready & (wait_cnt == CNT_W'(WAIT_LIMIT - 1));
      if (state == IDLE) begin
         stall_out = issue;
      end else begin
         stall_out = ~mem_ready & ~timeout_now;
      end
   end

   // Transfer FSM with all bus and result outputs registered.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         wait_cnt    <= '0;
         is_load     <= 1'b0;
         ctrl_hold   <= 3'b000;
         offset_hold <= 2'b00;
         mem_req     <= 1'b0;
         mem_we      <= 1'b0;
         mem_addr    <= 32'h0000_0000;
         mem_wdata   <= 32'h0000_0000;
         mem_be      <= 4'b0000;
         load_data   <= 32'h0000_0000;
         load_valid  <= 1'b0;
         bus_err     <= 1'b0;
         misalign    <= 1'b0;
      end else begin
         load_valid <= 1'b0;
         misalign   <= trap;
         case (state)
            IDLE: begin
               if (issue) begin
                  mem_req     <= 1'b1;
                  mem_we      <= dm_writeIn;
                  mem_addr    <= {ALUResIn[31:2], 2'b00};
                  mem_wdata   <= lane_wdata(dm_ctrlIn, RS2In);
                  mem_be      <= lane_be(dm_ctrlIn, ALUResIn[1:0]);
                  is_load     <= ~dm_writeIn;
                  ctrl_hold   <= dm_ctrlIn;
                  offset_hold <= ALUResIn[1:0];
                  wait_cnt    <= '0;
                  state       <= BUSY;
               end
            end
            BUSY: begin
               if (mem_ready) begin
                  mem_req <= 1'b0;
                  if (is_load) begin
                     load_data <= format_load(ctrl_hold, offset_hold, mem_rdata);
                  end
                  load_valid <= is_load;
                  state      <= IDLE;
               end else if (timeout_now) begin
                  mem_req    <= 1'b0;
                  bus_err    <= 1'b1;
                  load_data  <= 32'h0000_0000;
                  load_valid <= is_load;
                  state      <= IDLE;
               end else begin
                  wait_cnt <= wait_cnt + CNT_W'(1);
               end
            end
            default: begin
               state   <= IDLE;
               mem_req <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: stimulus pushes expected bus requests
// and load results into queues; a monitor pops and compares them whenever the
// DUT raises mem_req or pulses load_valid.
module tb_mem_access_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        valid_in;
   logic [31:0] ALUResIn;
   logic [31:0] RS2In;
   logic        dm_writeIn;
   logic [2:0]  dm_ctrlIn;
   logic [1:0]  ru_data_srcIn;
   logic        mem_ready;
   logic [31:0] mem_rdata;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_be;
   logic        stall_out;
   logic [31:0] load_data;
   logic        load_valid;
   logic        bus_err;
   logic        misalign;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
   } bus_exp_t;

   bus_exp_t    bus_q[$];
   logic [31:0] load_q[$];
   int          n_checks = 0;
   int          n_fail   = 0;
   bit          mon_en   = 1'b0;
   logic        req_prev = 1'b0;

   mem_access_unit #(.WAIT_LIMIT(16), .CNT_W(5)) dut (
      .clk(clk), .rst(rst), .valid_in(valid_in), .ALUResIn(ALUResIn), .RS2In(RS2In),
      .dm_writeIn(dm_writeIn), .dm_ctrlIn(dm_ctrlIn), .ru_data_srcIn(ru_data_srcIn),
      .mem_ready(mem_ready), .mem_rdata(mem_rdata), .mem_req(mem_req), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be), .stall_out(stall_out),
      .load_data(load_data), .load_valid(load_valid), .bus_err(bus_err), .misalign(misalign)
   );

   always #5 clk = ~clk;

   function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endfunction

   // Monitor: compare every new bus request and every load result against the queues.
   initial begin
      forever begin
         @(negedge clk);
         if (mon_en) begin
            if (mem_req === 1'b1 && req_prev !== 1'b1) begin
               if (bus_q.size() == 0) begin
                  check("unexpected mem_req", 32'(mem_req), 32'h0);
               end else begin
                  bus_exp_t e;
                  e = bus_q.pop_front();
                  check("mem_we", 32'(mem_we), 32'(e.we));
                  check("mem_addr", mem_addr, e.addr);
                  check("mem_be", 32'(mem_be), 32'(e.be));
                  if (e.we) check("mem_wdata", mem_wdata, e.wdata);
               end
            end
            req_prev = mem_req;
            if (load_valid === 1'b1) begin
               if (load_q.size() == 0) begin
                  check("unexpected load_valid", 32'(load_valid), 32'h0);
               end else begin
                  check("load_data", load_data, load_q.pop_front());
               end
            end
         end
      end
   end

   // One access held in EX/MEM until the DUT releases the stall. ready_k selects
   // the BUSY cycle (1-based) on which the bus answers; 0 means never.
   task automatic run_access(input string name, input logic we, input logic [2:0] ctrl,
                             input logic [1:0] src, input logic [31:0] addr, input logic [31:0] data,
                             input int ready_k, input logic [31:0] rdata,
                             input logic [31:0] exp_addr, input logic [3:0] exp_be,
                             input logic [31:0] exp_wdata, input bit exp_lv,
                             input logic [31:0] exp_load, input int exp_occ, input int exp_busy);
      int occ;
      int busy;
      bit done;
      occ  = 0;
      busy = 0;
      done = 1'b0;
      bus_q.push_back('{we, exp_addr, exp_wdata, exp_be});
      if (exp_lv) load_q.push_back(exp_load);
      @(posedge clk); #1;
      valid_in = 1'b1; dm_writeIn = we; dm_ctrlIn = ctrl; ru_data_srcIn = src;
      ALUResIn = addr; RS2In = data; mem_ready = 1'b0; mem_rdata = 32'h0;
      while (!done && occ < 64) begin
         if (mem_req === 1'b1) begin
            busy++;
            if (busy == ready_k) begin
               mem_ready = 1'b1;
               mem_rdata = rdata;
            end
         end
         @(negedge clk);
         occ++;
         if (stall_out === 1'b0) done = 1'b1;
         else begin
            @(posedge clk); #1;
         end
      end
      if (!done) $display("FAIL %s: stall never released within 64 cycles", name);
      check({name, " cycles in MEM"}, 32'(occ), 32'(exp_occ));
      check({name, " BUSY cycles"}, 32'(busy), 32'(exp_busy));
      @(posedge clk); #1;
      valid_in = 1'b0; dm_writeIn = 1'b0; ru_data_srcIn = 2'b00; mem_ready = 1'b0;
   endtask

   initial begin
      rst = 1'b1; valid_in = 1'b0; ALUResIn = 32'h0; RS2In = 32'h0; dm_writeIn = 1'b0;
      dm_ctrlIn = 3'b000; ru_data_srcIn = 2'b00; mem_ready = 1'b0; mem_rdata = 32'h0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset mem_req", 32'(mem_req), 32'h0);
      check("reset mem_be", 32'(mem_be), 32'h0);
      check("reset mem_addr", mem_addr, 32'h0);
      check("reset load_data", load_data, 32'h0);
      check("reset load_valid", 32'(load_valid), 32'h0);
      check("reset bus_err", 32'(bus_err), 32'h0);
      check("reset stall_out", 32'(stall_out), 32'h0);
      @(posedge clk); #1;
      rst = 1'b0;
      mon_en = 1'b1;

      // Live instruction that neither loads nor stores: no stall, no request.
      valid_in = 1'b1; ru_data_srcIn = 2'b00; dm_writeIn = 1'b0;
      @(negedge clk);
      check("non-mem stall_out", 32'(stall_out), 32'h0);
      @(posedge clk); #1;
      valid_in = 1'b0;
      @(negedge clk);
      check("non-mem mem_req", 32'(mem_req), 32'h0);

      //          name    we    ctrl    src    addr          data          k  rdata         exp_addr      be       wdata         lv  load          occ busy
      run_access("SW",   1'b1, 3'b010, 2'b00, 32'h0000_0100, 32'hDEAD_BEEF, 2, 32'h0,        32'h0000_0100, 4'b1111, 32'hDEAD_BEEF, 0, 32'h0,        3, 2);
      run_access("SB",   1'b1, 3'b000, 2'b00, 32'h0000_0103, 32'h1234_56A5, 1, 32'h0,        32'h0000_0100, 4'b1000, 32'hA5A5_A5A5, 0, 32'h0,        2, 1);
      run_access("LB",   1'b0, 3'b000, 2'b01, 32'h0000_0103, 32'h0,         1, 32'hA500_0000, 32'h0000_0100, 4'b1000, 32'h0,        1, 32'hFFFF_FFA5, 2, 1);
      run_access("LHU",  1'b0, 3'b101, 2'b01, 32'h0000_0102, 32'h0,         1, 32'h8001_1234, 32'h0000_0100, 4'b1100, 32'h0,        1, 32'h0000_8001, 2, 1);
      run_access("LH",   1'b0, 3'b001, 2'b01, 32'h0000_0100, 32'h0,         3, 32'h1234_F00D, 32'h0000_0100, 4'b0011, 32'h0,        1, 32'hFFFF_F00D, 4, 3);
      run_access("LBU",  1'b0, 3'b100, 2'b01, 32'h0000_0101, 32'h0,         1, 32'h0000_9A00, 32'h0000_0100, 4'b0010, 32'h0,        1, 32'h0000_009A, 2, 1);
      run_access("SHst", 1'b1, 3'b001, 2'b01, 32'h0000_0102, 32'h0000_BEEF, 1, 32'h0,        32'h0000_0100, 4'b1100, 32'hBEEF_BEEF, 0, 32'h0,        2, 1);
      run_access("L011", 1'b0, 3'b011, 2'b01, 32'h0000_0104, 32'h0,         1, 32'hCAFE_F00D, 32'h0000_0104, 4'b1111, 32'h0,        1, 32'hCAFE_F00D, 2, 1);

`ifdef MISALIGN_TRAP_EN
      @(posedge clk); #1;
      valid_in = 1'b1; dm_writeIn = 1'b0; dm_ctrlIn = 3'b010; ru_data_srcIn = 2'b01; ALUResIn = 32'h0000_0101;
      @(negedge clk);
      check("trap stall_out", 32'(stall_out), 32'h0);
      @(posedge clk); #1;
      valid_in = 1'b0; ru_data_srcIn = 2'b00;
      @(negedge clk);
      check("trap misalign", 32'(misalign), 32'h1);
      check("trap mem_req", 32'(mem_req), 32'h0);
      @(posedge clk); #1;
      @(negedge clk);
      check("trap misalign pulse", 32'(misalign), 32'h0);
`else
      run_access("LWmis", 1'b0, 3'b010, 2'b01, 32'h0000_0101, 32'h0,        1, 32'h1122_3344, 32'h0000_0100, 4'b1111, 32'h0,        1, 32'h1122_3344, 2, 1);
      @(negedge clk);
      check("misalign tied low", 32'(misalign), 32'h0);
`endif
      check("bus_err before timeout", 32'(bus_err), 32'h0);

      // LW with a silent bus: 16 BUSY cycles, abort, zero result, sticky error.
      run_access("LWto", 1'b0, 3'b010, 2'b01, 32'h0000_0200, 32'h0,         0, 32'h0,        32'h0000_0200, 4'b1111, 32'h0,        1, 32'h0,        17, 16);
      @(negedge clk);
      check("timeout mem_req", 32'(mem_req), 32'h0);
      check("timeout bus_err", 32'(bus_err), 32'h1);
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("bus_err sticky", 32'(bus_err), 32'h1);

      // Reset while BUSY: request aborted, no load result, error cleared.
      bus_q.push_back('{1'b0, 32'h0000_0300, 32'h0, 4'b1111});
      @(posedge clk); #1;
      valid_in = 1'b1; dm_writeIn = 1'b0; dm_ctrlIn = 3'b010; ru_data_srcIn = 2'b01;
      ALUResIn = 32'h0000_0300; mem_ready = 1'b0;
      @(posedge clk); #1;
      @(negedge clk);
      check("rst-busy mem_req before", 32'(mem_req), 32'h1);
      @(posedge clk); #1;
      rst = 1'b1; valid_in = 1'b0; ru_data_srcIn = 2'b00;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("rst-busy mem_req", 32'(mem_req), 32'h0);
      check("rst-busy stall_out", 32'(stall_out), 32'h0);
      check("rst-busy bus_err", 32'(bus_err), 32'h0);
      check("rst-busy load_valid", 32'(load_valid), 32'h0);
      repeat (4) @(posedge clk);
      @(negedge clk);
      check("bus queue drained", 32'(bus_q.size()), 32'h0);
      check("load queue drained", 32'(load_q.size()), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
